regfile_operand_fetch: RTL and testbench

Client-side read/bypass front end for the 2-read/2-write matrix register file. Accepts issue requests (thread, two source registers, destination), drives the regfile's registered read ports, merges same-edge writeback data the regfile would miss, and presents both 288-bit operands to the execute stage over a valid/ready handshake. It sits between the issue stage and the matrix ALU, and snoops the writeback bus that also drives the regfile write ports.

---
 rtl/regfile_pkg.sv | 41 ++++
 rtl/operand_fifo.sv | 55 +++++
 rtl/regfile_operand_fetch.sv | 112 +++++++++++
 tb/tb_regfile_operand_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing and payload types for the matrix register file operand path.
package regfile_pkg;

    localparam int unsigned REG_CNT           = 4;
    localparam int unsigned SUPERSCALAR_WIDTH = 4;
    localparam int unsigned REG_WIDTH         = 288;
    localparam int unsigned RW                = $clog2(REG_CNT);
    localparam int unsigned TW                = $clog2(SUPERSCALAR_WIDTH);
    localparam int unsigned AW                = TW + RW;
    localparam int unsigned FIFO_DEPTH        = 3;
    localparam int unsigned CW                = 2;

    typedef struct packed {
        logic [TW-1:0]        thread;
        logic [RW-1:0]        rd;
        logic [REG_WIDTH-1:0] a;
        logic [REG_WIDTH-1:0] b;
    } operand_req_t;

    // Returns {hit, data} for one operand against both writeback ports; D is
    // written after C by the regfile, so D takes priority.
    function automatic logic [REG_WIDTH:0] wb_bypass(
        input logic [AW-1:0]        addr,
        input logic                 c_we,
        input logic [AW-1:0]        c_addr,
        input logic [REG_WIDTH-1:0] c_data,
        input logic                 d_we,
        input logic [AW-1:0]        d_addr,
        input logic [REG_WIDTH-1:0] d_data
    );
        logic [REG_WIDTH:0] r;
        r = '0;
        if (d_we && (d_addr == addr)) begin
            r = {1'b1, d_data};
        end else if (c_we && (c_addr == addr)) begin
            r = {1'b1, c_data};
        end
        return r;
    endfunction

endpackage

// File: rtl/operand_fifo.sv
// Three-entry in-order FIFO of fetched operand bundles with occupancy count.
module operand_fifo
    import regfile_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  operand_req_t push_data,
    input  logic         pop,
    output operand_req_t head,
    output logic [CW-1:0] count
);

    operand_req_t  mem [FIFO_DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == CW'(FIFO_DEPTH - 1)) ? '0 : p + CW'(1);
    endfunction

    always_comb begin
        pop_en  = pop && (count != '0);
        push_en = push && ((count < CW'(FIFO_DEPTH)) || pop_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_en && !pop_en) begin
                count <= count + CW'(1);
            end else if (pop_en && !push_en) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/regfile_operand_fetch.sv
// Issue-side operand fetch: drives regfile read ports, merges same-edge
// writeback data, and queues complete operand bundles for the execute stage.
module regfile_operand_fetch
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TW-1:0]        in_thread,
    input  logic [RW-1:0]        in_ra,
    input  logic [RW-1:0]        in_rb,
    input  logic [RW-1:0]        in_rd,
    output logic [AW-1:0]        rf_a_addr,
    output logic [AW-1:0]        rf_b_addr,
    input  logic [REG_WIDTH-1:0] rf_a_data,
    input  logic [REG_WIDTH-1:0] rf_b_data,
    input  logic                 wb_c_we,
    input  logic                 wb_d_we,
    input  logic [AW-1:0]        wb_c_addr,
    input  logic [AW-1:0]        wb_d_addr,
    input  logic [REG_WIDTH-1:0] wb_c_data,
    input  logic [REG_WIDTH-1:0] wb_d_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TW-1:0]        out_thread,
    output logic [RW-1:0]        out_rd,
    output logic [REG_WIDTH-1:0] out_a,
    output logic [REG_WIDTH-1:0] out_b
);

    logic                 accept_c;
    logic [REG_WIDTH:0]   byp_a_c;
    logic [REG_WIDTH:0]   byp_b_c;

    logic                 s1_v;
    logic [TW-1:0]        s1_thread;
    logic [RW-1:0]        s1_rd;
    logic                 s1_hit_a;
    logic                 s1_hit_b;
    logic [REG_WIDTH-1:0] s1_byp_a;
    logic [REG_WIDTH-1:0] s1_byp_b;

    operand_req_t         push_data;
    operand_req_t         head;
    logic [CW-1:0]        fifo_count;
    logic                 pop;

    assign rf_a_addr = {in_thread, in_ra};
    assign rf_b_addr = {in_thread, in_rb};

    // Depends only on registered occupancy, never on out_ready.
    assign in_ready = ((3'(fifo_count) + 3'(s1_v)) < 3'(FIFO_DEPTH));
    assign accept_c = in_valid && in_ready;

    always_comb begin
        byp_a_c = wb_bypass(rf_a_addr, wb_c_we, wb_c_addr, wb_c_data,
                            wb_d_we, wb_d_addr, wb_d_data);
        byp_b_c = wb_bypass(rf_b_addr, wb_c_we, wb_c_addr, wb_c_data,
                            wb_d_we, wb_d_addr, wb_d_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_thread <= '0;
            s1_rd     <= '0;
            s1_hit_a  <= 1'b0;
            s1_hit_b  <= 1'b0;
            s1_byp_a  <= '0;
            s1_byp_b  <= '0;
        end else begin
            s1_v <= accept_c;
            if (accept_c) begin
                s1_thread <= in_thread;
                s1_rd     <= in_rd;
                s1_hit_a  <= byp_a_c[REG_WIDTH];
                s1_hit_b  <= byp_b_c[REG_WIDTH];
                s1_byp_a  <= byp_a_c[REG_WIDTH-1:0];
                s1_byp_b  <= byp_b_c[REG_WIDTH-1:0];
            end
        end
    end

    // Regfile read data is valid now, one edge after the address was presented.
    always_comb begin
        push_data        = '0;
        push_data.thread = s1_thread;
        push_data.rd     = s1_rd;
        push_data.a      = s1_hit_a ? s1_byp_a : rf_a_data;
        push_data.b      = s1_hit_b ? s1_byp_b : rf_b_data;
    end

    assign pop = out_valid && out_ready;

    operand_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_v),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign out_valid  = (fifo_count != '0);
    assign out_thread = head.thread;
    assign out_rd     = head.rd;
    assign out_a      = head.a;
    assign out_b      = head.b;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed and randomized bench for regfile_operand_fetch with a regfile model
// and a snapshot-based expected-operand queue.
module tb_regfile_operand_fetch;
    import regfile_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [TW-1:0]        in_thread;
    logic [RW-1:0]        in_ra, in_rb, in_rd;
    logic [AW-1:0]        rf_a_addr, rf_b_addr;
    logic [REG_WIDTH-1:0] rf_a_data, rf_b_data;
    logic                 wb_c_we, wb_d_we;
    logic [AW-1:0]        wb_c_addr, wb_d_addr;
    logic [REG_WIDTH-1:0] wb_c_data, wb_d_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [TW-1:0]        out_thread;
    logic [RW-1:0]        out_rd;
    logic [REG_WIDTH-1:0] out_a, out_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_thread(in_thread), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
        .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr),
        .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
        .wb_c_we(wb_c_we), .wb_d_we(wb_d_we),
        .wb_c_addr(wb_c_addr), .wb_d_addr(wb_d_addr),
        .wb_c_data(wb_c_data), .wb_d_data(wb_d_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_thread(out_thread), .out_rd(out_rd),
        .out_a(out_a), .out_b(out_b)
    );

    // Regfile model: registered reads return pre-edge contents; D written after C.
    logic [REG_WIDTH-1:0] rf_mem [1 << AW];
    always @(posedge clk) begin
        rf_a_data <= rf_mem[rf_a_addr];
        rf_b_data <= rf_mem[rf_b_addr];
        if (wb_c_we) rf_mem[wb_c_addr] <= wb_c_data;
        if (wb_d_we) rf_mem[wb_d_addr] <= wb_d_data;
    end

    typedef struct {
        logic [TW-1:0]        thread;
        logic [RW-1:0]        rd;
        logic [REG_WIDTH-1:0] a;
        logic [REG_WIDTH-1:0] b;
        int                   edge_no;
    } exp_t;

    exp_t q[$];
    int   edge_cnt    = 0;
    int   outstanding = 0;
    int   accepts     = 0;

    task automatic chk(input string tag, input logic [REG_WIDTH-1:0] obs,
                       input logic [REG_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs in the low phase, apply inputs across the edge.
    task automatic cycle();
        logic          acc;
        logic          pop;
        logic [AW-1:0] aa, ab;
        exp_t          e;
        chk("in_ready", REG_WIDTH'(in_ready), REG_WIDTH'(outstanding < 3));
        chk("out_valid", REG_WIDTH'(out_valid),
            REG_WIDTH'(q.size() > 0 && q[0].edge_no <= edge_cnt - 1));
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        aa  = {in_thread, in_ra};
        ab  = {in_thread, in_rb};
        e   = '{thread: in_thread, rd: in_rd, a: '0, b: '0, edge_no: 0};
        if (pop) begin
            if (q.size() == 0) begin
                chk("pop_unexpected", REG_WIDTH'(1), REG_WIDTH'(0));
            end else begin
                chk("out_thread", REG_WIDTH'(out_thread), REG_WIDTH'(q[0].thread));
                chk("out_rd", REG_WIDTH'(out_rd), REG_WIDTH'(q[0].rd));
                chk("out_a", out_a, q[0].a);
                chk("out_b", out_b, q[0].b);
                void'(q.pop_front());
                outstanding--;
            end
        end
        @(posedge clk);
        edge_cnt++;
        #1;
        if (acc) begin
            e.a       = rf_mem[aa];
            e.b       = rf_mem[ab];
            e.edge_no = edge_cnt;
            q.push_back(e);
            outstanding++;
            accepts++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wb_c_we  = 1'b0;
        wb_d_we  = 1'b0;
    endtask

    task automatic rand_req();
        in_valid  = 1'b1;
        in_thread = TW'($urandom_range(0, SUPERSCALAR_WIDTH - 1));
        in_ra     = RW'($urandom_range(0, REG_CNT - 1));
        in_rb     = RW'($urandom_range(0, REG_CNT - 1));
        in_rd     = RW'($urandom_range(0, REG_CNT - 1));
    endtask

    task automatic rand_wb();
        wb_c_we   = 1'($urandom_range(0, 1));
        wb_d_we   = 1'($urandom_range(0, 1));
        wb_c_addr = AW'($urandom_range(0, (1 << AW) - 1));
        wb_d_addr = AW'($urandom_range(0, (1 << AW) - 1));
        wb_c_data = {9{$urandom()}};
        wb_d_data = {9{$urandom()}};
    endtask

    task automatic issue(input int thr, input int ra, input int rb, input int rd);
        in_valid  = 1'b1;
        in_thread = TW'(thr);
        in_ra     = RW'(ra);
        in_rb     = RW'(rb);
        in_rd     = RW'(rd);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
        chk("drain_empty", REG_WIDTH'(q.size()), REG_WIDTH'(0));
    endtask

    logic [7:0] bt;
    int         acc0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_thread = '0; in_ra = '0; in_rb = '0;
        in_rd = '0; out_ready = 1'b0; wb_c_we = 1'b0; wb_d_we = 1'b0;
        wb_c_addr = '0; wb_d_addr = '0; wb_c_data = '0; wb_d_data = '0;
        #12;
        chk("rst_out_valid", REG_WIDTH'(out_valid), REG_WIDTH'(0));
        chk("rst_in_ready", REG_WIDTH'(in_ready), REG_WIDTH'(1));
        chk("rst_out_a", out_a, '0);
        chk("rst_out_b", out_b, '0);
        chk("rst_out_tag", REG_WIDTH'({out_thread, out_rd}), REG_WIDTH'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Preload every register; addr 9 (t2,r1) = AA.., addr 11 (t2,r3) = BB..
        for (int i = 0; i < (1 << AW); i++) begin
            bt = (i == 9) ? 8'hAA : (i == 11) ? 8'hBB : 8'(i * 17 + 3);
            wb_c_we = 1'b1; wb_c_addr = AW'(i); wb_c_data = {36{bt}};
            cycle();
        end

        // Basic fetch with two-cycle latency.
        issue(2, 1, 3, 2);
        cycle();
        cycle();
        bt = 8'hAA; chk("t1_out_a", out_a, {36{bt}});
        bt = 8'hBB; chk("t1_out_b", out_b, {36{bt}});
        chk("t1_out_thread", REG_WIDTH'(out_thread), REG_WIDTH'(2));
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // Same-edge bypass on both ports to the same register: D wins.
        issue(2, 1, 3, 1);
        wb_c_we = 1'b1; wb_c_addr = AW'(9); bt = 8'h11; wb_c_data = {36{bt}};
        wb_d_we = 1'b1; wb_d_addr = AW'(9); bt = 8'h22; wb_d_data = {36{bt}};
        cycle();
        cycle();
        bt = 8'h22; chk("byp_out_a", out_a, {36{bt}});
        bt = 8'hBB; chk("byp_out_b", out_b, {36{bt}});
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // Snapshot: a write one edge after accept is not reflected.
        issue(2, 1, 1, 3);
        cycle();
        wb_c_we = 1'b1; wb_c_addr = AW'(9); bt = 8'h33; wb_c_data = {36{bt}};
        cycle();
        bt = 8'h22; chk("snap_out_a", out_a, {36{bt}});
        chk("snap_out_b", out_b, {36{bt}});
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // Backpressure: only three requests fit.
        acc0 = accepts;
        for (int i = 0; i < 4; i++) begin
            rand_req();
            cycle();
        end
        chk("bp_accepts", REG_WIDTH'(accepts - acc0), REG_WIDTH'(3));
        chk("bp_in_ready", REG_WIDTH'(in_ready), REG_WIDTH'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 10 && accepts - acc0 < 4; i++) begin
            issue(1, 2, 0, 3);
            cycle();
        end
        chk("bp_fourth", REG_WIDTH'(accepts - acc0), REG_WIDTH'(4));
        drain();

        // Streaming at full rate with random writebacks.
        acc0 = accepts;
        for (int i = 0; i < 16; i++) begin
            rand_req();
            rand_wb();
            cycle();
        end
        chk("stream_accepts", REG_WIDTH'(accepts - acc0), REG_WIDTH'(16));
        drain();

        // Fully random traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) rand_req();
            rand_wb();
            out_ready = ($urandom_range(0, 9) < 6);
            cycle();
        end
        drain();

        // Reset with two entries queued drops them immediately.
        out_ready = 1'b0;
        rand_req(); cycle();
        rand_req(); cycle();
        cycle();
        chk("pre_rst_valid", REG_WIDTH'(out_valid), REG_WIDTH'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", REG_WIDTH'(out_valid), REG_WIDTH'(0));
        chk("mid_rst_in_ready", REG_WIDTH'(in_ready), REG_WIDTH'(1));
        q.delete();
        outstanding = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("post_rst_valid", REG_WIDTH'(out_valid), REG_WIDTH'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
